// File: rtl/conv_pad_streamer.sv
// conv_pad_streamer: turns an unpadded pixel stream into the zero-padded
// raster conv_top consumes, then appends zero flush beats to drain the
// line buffers and kernel window.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for go; cfg sampled on go
// STREAM | walking row/col/grp over the padded raster, one beat per load
// FLUSH  | loading cfg_flush_beats zero beats (down-counter)
// DONE   | waiting for the last output beat to drain, then pulse done
module conv_pad_streamer #(
  parameter int DATA_W = 64,
  parameter int DIM_W  = 16,
  parameter int GRP_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DIM_W-1:0]  cfg_img_width,
  input  logic [DIM_W-1:0]  cfg_img_height,
  input  logic [GRP_W-1:0]  cfg_ci_groups,
  input  logic              cfg_pad,
  input  logic [DIM_W-1:0]  cfg_flush_beats,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err_last
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  localparam logic [DIM_W:0]   POS_ONE = {{DIM_W{1'b0}}, 1'b1};
  localparam logic [DIM_W-1:0] FL_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [GRP_W-1:0] GRP_ONE = {{(GRP_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [DIM_W-1:0]  w_q, h_q, flush_q, flush_cnt;
  logic [GRP_W-1:0]  g_q, grp;
  logic              pad_q;
  logic [DIM_W:0]    row, col;

  logic [DIM_W:0]    pad_one, int_last_col, int_last_row, wp_m1, hp_m1;
  logic [GRP_W-1:0]  g_m1;
  logic              interior, at_grp_last, at_col_last, at_row_last;
  logic              final_pos, final_int, can_load, s_hs, stream_adv;

  // Padded-raster geometry: the interior occupies [pad, dim-1+pad], the
  // padded extent ends one further out when a zero ring is present.
  assign pad_one      = {{DIM_W{1'b0}}, pad_q};
  assign int_last_col = {1'b0, w_q} - POS_ONE + pad_one;
  assign int_last_row = {1'b0, h_q} - POS_ONE + pad_one;
  assign wp_m1        = int_last_col + pad_one;
  assign hp_m1        = int_last_row + pad_one;
  assign g_m1         = g_q - GRP_ONE;

  assign interior    = !pad_q || (row != '0 && row != hp_m1 && col != '0 && col != wp_m1);
  assign at_grp_last = (grp == g_m1);
  assign at_col_last = (col == wp_m1);
  assign at_row_last = (row == hp_m1);
  assign final_pos   = at_grp_last && at_col_last && at_row_last;
  assign final_int   = at_grp_last && (col == int_last_col) && (row == int_last_row);

  // Output stage can take a new beat when empty or being drained this cycle.
  assign can_load   = !m_valid || m_ready;
  assign s_ready    = (state == STREAM) && interior && can_load;
  assign s_hs       = s_valid && s_ready;
  assign stream_adv = (state == STREAM) && can_load && (!interior || s_valid);

  // Sequencer, raster counters and registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      g_q       <= '0;
      pad_q     <= 1'b0;
      flush_q   <= '0;
      flush_cnt <= '0;
      row       <= '0;
      col       <= '0;
      grp       <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (s_hs && (s_last != final_int)) err_last <= 1'b1;

      case (state)
        IDLE: begin
          if (go) begin
            w_q      <= cfg_img_width;
            h_q      <= cfg_img_height;
            g_q      <= cfg_ci_groups;
            pad_q    <= cfg_pad;
            flush_q  <= cfg_flush_beats;
            err_last <= 1'b0;
            busy     <= 1'b1;
            row      <= '0;
            col      <= '0;
            grp      <= '0;
            if (cfg_img_width == '0 || cfg_img_height == '0 || cfg_ci_groups == '0)
              state <= DONE;
            else
              state <= STREAM;
          end
        end

        STREAM: begin
          if (stream_adv) begin
            m_valid <= 1'b1;
            m_data  <= interior ? s_data : '0;
            m_last  <= final_pos;
            if (at_grp_last) begin
              grp <= '0;
              if (at_col_last) begin
                col <= '0;
                row <= at_row_last ? '0 : row + POS_ONE;
              end else begin
                col <= col + POS_ONE;
              end
            end else begin
              grp <= grp + GRP_ONE;
            end
            if (final_pos) begin
              flush_cnt <= flush_q;
              state     <= (flush_q != '0) ? FLUSH : DONE;
            end
          end
        end

        FLUSH: begin
          if (can_load) begin
            m_valid   <= 1'b1;
            m_data    <= '0;
            m_last    <= 1'b0;
            flush_cnt <= flush_cnt - FL_ONE;
            if (flush_cnt == FL_ONE) state <= DONE;
          end
        end

        DONE: begin
          // can_load here means the final beat is gone or leaves this edge.
          if (can_load) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pad_streamer.sv
// Testbench for conv_pad_streamer: randomized handshakes against a
// raster-walk reference model of the padded output stream.
module tb_conv_pad_streamer;

  logic        clk, rst, go;
  logic [15:0] cfg_img_width, cfg_img_height, cfg_flush_beats;
  logic [9:0]  cfg_ci_groups;
  logic        cfg_pad;
  logic [63:0] s_data, m_data;
  logic        s_valid, s_ready, s_last;
  logic        m_valid, m_last, m_ready;
  logic        busy, done, err_last;

  int tests = 0;
  int fails = 0;

  logic [63:0] src[$];
  logic [64:0] got[$];
  int          src_cnt;

  conv_pad_streamer dut (
    .clk(clk), .rst(rst), .go(go),
    .cfg_img_width(cfg_img_width), .cfg_img_height(cfg_img_height),
    .cfg_ci_groups(cfg_ci_groups), .cfg_pad(cfg_pad),
    .cfg_flush_beats(cfg_flush_beats),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done), .err_last(err_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one job; rst_at >= 0 aborts with reset once that many beats were accepted.
  task automatic run_job(input int w, input int h, input int g, input bit pad, input int fl,
                         input int rdy_pct, input int val_pct, input bit inc,
                         input int err_idx, input int go2_at, input int rst_at);
    int n, hp, wp, sidx, last_hs, done_cyc, k;
    bit hold, fin, exp_err, mv_seen, interior;
    logic [63:0] pd;
    logic        pl;
    logic [64:0] exp_q[$];

    n  = w * h * g;
    hp = h + (pad ? 2 : 0);
    wp = w + (pad ? 2 : 0);
    src.delete();
    got.delete();
    for (int i = 0; i < n; i++) src.push_back(inc ? 64'(i + 1) : {$urandom(), $urandom()});

    k = 0;
    if (n > 0) begin
      for (int r = 0; r < hp; r++)
        for (int c = 0; c < wp; c++)
          for (int gg = 0; gg < g; gg++) begin
            interior = !pad || (r > 0 && r < hp - 1 && c > 0 && c < wp - 1);
            exp_q.push_back({(r == hp - 1 && c == wp - 1 && gg == g - 1),
                             interior ? src[k] : 64'd0});
            if (interior) k++;
          end
      for (int i = 0; i < fl; i++) exp_q.push_back('0);
    end

    cfg_img_width   = 16'(w);
    cfg_img_height  = 16'(h);
    cfg_ci_groups   = 10'(g);
    cfg_pad         = pad;
    cfg_flush_beats = 16'(fl);

    sidx = 0; hold = 0; fin = 0; exp_err = 0; mv_seen = 0;
    last_hs = -1; done_cyc = -1; pd = '0; pl = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      if (hold) begin
        check("hold_valid", 65'(m_valid), 65'(1));
        check("hold_data", {1'b0, m_data}, {1'b0, pd});
        check("hold_last", 65'(m_last), 65'(pl));
      end
      if (cyc >= 1) check("err_last", 65'(err_last), 65'(exp_err));
      if (cyc == 1) check("busy_start", 65'(busy), 65'(1));
      if (m_valid) mv_seen = 1;
      if (cyc >= 1 && done) begin
        done_cyc = cyc;
        fin = 1;
      end
      go      = (cyc == 0) || (cyc == go2_at);
      m_ready = ($urandom_range(99) < rdy_pct);
      s_valid = (sidx < n) && ($urandom_range(99) < val_pct);
      s_data  = (sidx < n) ? src[sidx] : 64'd0;
      s_last  = (sidx == n - 1) || (sidx == err_idx);
      #1;
      if (m_valid && m_ready) begin
        got.push_back({m_last, m_data});
        last_hs = cyc;
      end
      if (s_valid && s_ready) begin
        if (s_last != (sidx == n - 1)) exp_err = 1;
        sidx++;
      end
      hold = m_valid && !m_ready;
      pd   = m_data;
      pl   = m_last;
      if (rst_at >= 0 && got.size() == rst_at) begin
        rst = 1'b0;
        #1;
        check("rst_m_valid", 65'(m_valid), 65'(0));
        check("rst_busy", 65'(busy), 65'(0));
        check("rst_done", 65'(done), 65'(0));
        @(negedge clk);
        go = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        rst = 1'b1;
        return;
      end
    end
    go = 1'b0;
    s_valid = 1'b0;

    check("done_seen", 65'(fin), 65'(1));
    @(negedge clk);
    check("done_pulse_end", 65'(done), 65'(0));
    check("busy_end", 65'(busy), 65'(0));

    check("beat_count", 65'(got.size()), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check("beat", got[i], exp_q[i]);
    src_cnt = sidx;
    check("src_count", 65'(sidx), 65'(n));
    if (n > 0) begin
      check("done_latency", 65'(done_cyc), 65'(last_hs + 1));
    end else begin
      check("zero_done_fast", 65'(done_cyc <= 3), 65'(1));
      check("zero_no_valid", 65'(mv_seen), 65'(0));
    end
  endtask

  task automatic scenario1_checks();
    int lasts;
    for (int i = 0; i <= 10; i++) check("s1_border_zero", got[i], 65'd0);
    check("s1_beat11", got[11], 65'd1);
    check("s1_beat18", got[18], 65'd8);
    check("s1_beat21", got[21], 65'd9);
    check("s1_beat99_last", 65'(got[99][64]), 65'(1));
    lasts = 0;
    foreach (got[i]) if (got[i][64]) lasts++;
    check("s1_single_last", 65'(lasts), 65'(1));
    check("s1_total", 65'(got.size()), 65'(124));
    check("s1_src_hs", 65'(src_cnt), 65'(64));
  endtask

  initial begin
    rst = 1'b0; go = 1'b0;
    cfg_img_width = '0; cfg_img_height = '0; cfg_ci_groups = '0;
    cfg_pad = 1'b0; cfg_flush_beats = '0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_valid0", 65'(m_valid), 65'(0));
    check("rst_m_data0", {1'b0, m_data}, 65'(0));
    check("rst_m_last0", 65'(m_last), 65'(0));
    check("rst_s_ready0", 65'(s_ready), 65'(0));
    check("rst_busy0", 65'(busy), 65'(0));
    check("rst_done0", 65'(done), 65'(0));
    check("rst_err0", 65'(err_last), 65'(0));
    rst = 1'b1;
    @(negedge clk);

    // 8x8, pad, 24 flush, free-flowing
    run_job(8, 8, 1, 1'b1, 24, 100, 100, 1'b1, -1, -1, -1);
    scenario1_checks();

    // 2x2, G=2, no pad, no flush, random data
    run_job(2, 2, 2, 1'b0, 0, 100, 100, 1'b0, -1, -1, -1);
    check("s2_count", 65'(got.size()), 65'(8));
    check("s2_last", 65'(got[7][64]), 65'(1));

    // Same as first, random backpressure and source gaps
    run_job(8, 8, 1, 1'b1, 24, 50, 50, 1'b1, -1, -1, -1);
    scenario1_checks();

    // Early s_last on beat 10
    run_job(8, 8, 1, 1'b1, 24, 80, 80, 1'b1, 10, -1, -1);
    check("err_sticky", 65'(err_last), 65'(1));
    check("err_total", 65'(got.size()), 65'(124));

    // Zero width: no beats, quick done; err cleared by this go
    run_job(0, 5, 1, 1'b1, 4, 100, 100, 1'b0, -1, -1, -1);
    check("err_cleared", 65'(err_last), 65'(0));

    // Second go while busy is ignored
    run_job(4, 3, 2, 1'b1, 5, 70, 70, 1'b0, -1, 10, -1);
    check("go2_count", 65'(got.size()), 65'(65));

    // Reset mid-stream, then a fresh full run
    run_job(8, 8, 1, 1'b1, 24, 100, 100, 1'b1, -1, -1, 40);
    check("post_rst_valid", 65'(m_valid), 65'(0));
    run_job(8, 8, 1, 1'b1, 24, 100, 100, 1'b1, -1, -1, -1);
    scenario1_checks();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
